// File: rtl/control_filtro_if.sv
// control_filtro_if: coefficient, sample, arithmetic-unit and result signals of the filter controller
interface control_filtro_if #(parameter int N = 24);
    logic         coef_we;
    logic [2:0]   coef_addr;
    logic [N-1:0] coef_data;
    logic [N-1:0] muestra;
    logic         muestra_valida;
    logic [N-1:0] Valores;
    logic [N-1:0] Constantes_G;
    logic [N-1:0] Multip_G;
    logic [N-1:0] Entrada_G;
    logic [N-1:0] salida;
    logic         salida_valida;
    logic         ocupado;
    logic         muestra_perdida;
    modport master (
        output coef_we, coef_addr, coef_data, muestra, muestra_valida, Valores,
        input  Constantes_G, Multip_G, Entrada_G, salida, salida_valida, ocupado, muestra_perdida
    );
    modport slave (
        input  coef_we, coef_addr, coef_data, muestra, muestra_valida, Valores,
        output Constantes_G, Multip_G, Entrada_G, salida, salida_valida, ocupado, muestra_perdida
    );
endinterface

// File: rtl/control_filtro.sv
// control_filtro: K-tap FIR sequencer driving an external multiply-accumulate unit one tap per cycle
module control_filtro #(
    parameter int N = 24,
    parameter int K = 5
) (
    input logic clk,
    input logic reset,
    control_filtro_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t       state;
    logic [2:0]   idx;
    logic [N-1:0] acc;
    logic [N-1:0] coef [K];
    logic [N-1:0] x [K];
    logic         mac;
    assign mac = state == MAC;
    assign bus.Constantes_G = mac ? coef[idx] : '0;
    assign bus.Multip_G     = mac ? x[idx] : '0;
    assign bus.Entrada_G    = mac ? acc : '0;
    // coefficient bank: writes land at the edge, so an operand read this cycle still sees the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) coef[i] <= '0;
        end else if (bus.coef_we && {1'b0, bus.coef_addr} < 4'(K)) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end
    // sequencer: accept a sample, walk K taps through the arithmetic unit, then publish the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            idx                 <= '0;
            acc                 <= '0;
            bus.salida          <= '0;
            bus.salida_valida   <= 1'b0;
            bus.ocupado         <= 1'b0;
            bus.muestra_perdida <= 1'b0;
            for (int i = 0; i < K; i++) x[i] <= '0;
        end else begin
            bus.salida_valida   <= state == DONE;
            bus.muestra_perdida <= bus.muestra_valida && bus.ocupado;
            case (state)
                IDLE: if (bus.muestra_valida) begin
                    x[0] <= bus.muestra;
                    for (int i = 1; i < K; i++) x[i] <= x[i-1];
                    acc         <= '0;
                    idx         <= '0;
                    state       <= MAC;
                    bus.ocupado <= 1'b1;
                end
                MAC: begin
                    acc <= bus.Valores;
                    idx <= idx + 3'd1;
                    if (idx == 3'(K-1)) begin
                        bus.salida <= bus.Valores;
                        state      <= DONE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.ocupado <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_filtro.sv
// tb_control_filtro: directed vectors against hand-computed FIR results and timing
module tb_control_filtro;
    localparam int N = 24;
    localparam int K = 5;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    control_filtro_if #(.N(N)) bus ();
    control_filtro #(.N(N), .K(K)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    assign bus.Valores = bus.Entrada_G + bus.Constantes_G * bus.Multip_G;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.muestra = '0;
        bus.muestra_valida = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask
    task automatic write_coef(input logic [2:0] a, input logic [N-1:0] d);
        bus.coef_we = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we = 1'b0;
    endtask
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.salida_valida && n < 20) begin
            tick();
            n++;
        end
    endtask
    task automatic run_sample(input string tag, input logic [N-1:0] s, input logic [N-1:0] e);
        int n;
        bus.muestra = s;
        bus.muestra_valida = 1'b1;
        tick();
        bus.muestra_valida = 1'b0;
        chk({tag, "_busy"}, 32'(bus.ocupado), 32'd1);
        chk({tag, "_op0"}, 32'(bus.Multip_G), 32'(s));
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n + 1), 32'(K + 2));
        chk({tag, "_val"}, 32'(bus.salida), 32'(e));
        tick();
    endtask
    initial begin
        int n;
        int seen;
        checks = 0;
        errors = 0;
        do_reset();
        chk("rst_salida", 32'(bus.salida), 32'd0);
        chk("rst_valida", 32'(bus.salida_valida), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_perdida", 32'(bus.muestra_perdida), 32'd0);
        chk("rst_ops", 32'(bus.Constantes_G | bus.Multip_G | bus.Entrada_G), 32'd0);
        for (int i = 0; i < K; i++) write_coef(3'(i), 24'd1);
        run_sample("ones1", 24'd1, 24'd1);
        run_sample("ones2", 24'd2, 24'd3);
        run_sample("ones3", 24'd3, 24'd6);
        run_sample("ones4", 24'd4, 24'd10);
        run_sample("ones5", 24'd5, 24'd15);
        do_reset();
        write_coef(3'd0, 24'd2);
        write_coef(3'd4, 24'hFFFFFF);
        run_sample("imp0", 24'd10, 24'd20);
        run_sample("imp1", 24'd0, 24'd0);
        run_sample("imp2", 24'd0, 24'd0);
        run_sample("imp3", 24'd0, 24'd0);
        run_sample("imp4", 24'd0, 24'hFFFFF6);
        run_sample("imp5", 24'd0, 24'd0);
        do_reset();
        for (int i = 0; i < K; i++) write_coef(3'(i), 24'd1);
        bus.muestra = 24'd7;
        bus.muestra_valida = 1'b1;
        tick();
        bus.muestra_valida = 1'b0;
        tick();
        tick();
        chk("drop_busy", 32'(bus.ocupado), 32'd1);
        bus.muestra = 24'd9;
        bus.muestra_valida = 1'b1;
        tick();
        bus.muestra_valida = 1'b0;
        chk("drop_pulse", 32'(bus.muestra_perdida), 32'd1);
        tick();
        chk("drop_pulse_end", 32'(bus.muestra_perdida), 32'd0);
        wait_valid(n);
        chk("drop_seen", 32'(bus.salida_valida), 32'd1);
        chk("drop_val", 32'(bus.salida), 32'd7);
        tick();
        run_sample("after_drop", 24'd5, 24'd12);
        bus.muestra = 24'd3;
        bus.muestra_valida = 1'b1;
        tick();
        bus.muestra_valida = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort_salida", 32'(bus.salida), 32'd0);
        chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
        chk("abort_ops", 32'(bus.Constantes_G | bus.Multip_G | bus.Entrada_G), 32'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.salida_valida) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        run_sample("post_rst", 24'd4, 24'd0);
        do_reset();
        for (int i = 0; i < K; i++) write_coef(3'(i), 24'(i + 1));
        run_sample("ramp1", 24'd1, 24'd1);
        run_sample("ramp2", 24'd2, 24'd4);
        write_coef(3'd6, 24'd100);
        write_coef(3'd5, 24'd100);
        write_coef(3'd7, 24'd100);
        run_sample("oob1", 24'd3, 24'd10);
        run_sample("oob2", 24'd5, 24'd21);
        write_coef(3'd2, 24'd9);
        bus.muestra = 24'd1;
        bus.muestra_valida = 1'b1;
        tick();
        bus.muestra_valida = 1'b0;
        tick();
        tick();
        chk("wr_mid_old_op", 32'(bus.Constantes_G), 32'd9);
        bus.coef_we = 1'b1;
        bus.coef_addr = 3'd2;
        bus.coef_data = 24'd3;
        #1;
        chk("wr_mid_same_cycle", 32'(bus.Constantes_G), 32'd9);
        tick();
        bus.coef_we = 1'b0;
        wait_valid(n);
        chk("wr_mid_val", 32'(bus.salida), 32'd51);
        tick();
        run_sample("wr_next", 24'd0, 24'd39);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_filtro.md
CONTROL_FILTRO -- requirements
Module: control_filtro

Interface
REQ-001 Parameter N, default 24: data width of samples, coefficients, accumulator and result.
REQ-002 Parameter K, default 5: number of taps (coefficients and delay-line stages), 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coef_we  input  1  coefficient write strobe.
REQ-006 coef_addr  input  3  coefficient index; values >= K ignored.
REQ-007 coef_data  input  N  coefficient value, two's complement.
REQ-008 muestra  input  N  new input sample, two's complement.
REQ-009 muestra_valida  input  1  one-cycle strobe qualifying muestra.
REQ-010 Valores  input  N  result returned by the external arithmetic unit (Entrada_G + Constantes_G*Multip_G, truncated to N), combinational, same cycle.
REQ-011 Constantes_G  output  N  coefficient operand to the arithmetic unit.
REQ-012 Multip_G  output  N  sample operand to the arithmetic unit.
REQ-013 Entrada_G  output  N  running-sum operand to the arithmetic unit.
REQ-014 salida  output  N  filter result, held until next result.
REQ-015 salida_valida  output  1  one-cycle pulse when salida updates.
REQ-016 ocupado  output  1  high while a computation is in progress.
REQ-017 muestra_perdida  output  1  one-cycle pulse when a sample is dropped.

Function
REQ-018 FSM states: IDLE, MAC, DONE; encoding free.
REQ-019 IDLE + muestra_valida: delay line shifts (x[0] <= muestra, x[i] <= x[i-1]; x[K-1] discarded), acc <= 0, idx <= 0, next state MAC.
REQ-020 MAC, every cycle: Constantes_G = coef[idx], Multip_G = x[idx], Entrada_G = acc; acc <= Valores; idx <= idx+1.
REQ-021 MAC with idx == K-1: salida <= Valores, next state DONE; MAC lasts exactly K cycles.
REQ-022 DONE: salida_valida = 1 for exactly this cycle; next state IDLE unconditionally.
REQ-023 Latency: muestra_valida sampled at edge E -> salida_valida high in cycle after edge E+K+1; K+2 cycles per sample including the IDLE acceptance cycle.
REQ-024 In IDLE and DONE, Constantes_G, Multip_G, Entrada_G = 0.
REQ-025 ocupado = 1 in MAC and DONE, 0 in IDLE.
REQ-026 muestra_valida while ocupado = 1: sample dropped, delay line unchanged, muestra_perdida pulses the following cycle.
REQ-027 coef_we with coef_addr < K: coef[coef_addr] <= coef_data at next edge in any state; a write to the index being read in MAC affects only later cycles, not the current operand.
REQ-028 coef_we with coef_addr >= K: no state change.
REQ-029 No saturation in this block; overflow behaviour is that of the arithmetic unit.

Reset
REQ-030 reset asserted: immediately state = IDLE, idx = 0, acc = 0, all coef = 0, all x = 0, salida = 0, salida_valida = 0, ocupado = 0, muestra_perdida = 0, operand outputs = 0.
REQ-031 reset mid-MAC aborts the computation; no salida_valida issued for the aborted sample.
REQ-032 First muestra_valida after reset release is accepted normally.

Verification (bench models Valores = Entrada_G + low N bits of Constantes_G*Multip_G, integer)
REQ-033 Load coef = {1,1,1,1,1}, send samples 1,2,3,4,5 spaced 8 cycles -> salida = 1,3,6,10,15; each salida_valida exactly 7 cycles (K+2) after its strobe.
REQ-034 coef = {2,0,0,0,-1}, samples 10,0,0,0,0,0 -> salida = 20,0,0,0,-10 (0xFFFFF6),0.
REQ-035 Strobe sample 7, then strobe sample 9 three cycles later -> muestra_perdida pulses once, result uses only 7, next accepted sample shifts after 7.
REQ-036 Assert reset at 3rd MAC cycle -> all outputs 0 immediately, no salida_valida; later sample 4 with coef[0]=0 after reset -> salida = 0.
REQ-037 coef_we with coef_addr = 6 (K=5) -> no coefficient changes, next result identical to prior configuration.
REQ-038 Write coef[2] = 3 during MAC cycle reading idx 2 -> current result uses old coef[2], next sample's result uses 3.
